// File: rtl/gate_chk_pkg.sv
// Shared types and golden gate model for the 2-input gate bank sweep checker.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DRIVE       = 2'd1,
      SETTLE_WAIT = 2'd2,
      DONE        = 2'd3
   } state_t;

   localparam int NUM_VEC = 4;

   // bit order {nor, nand, xor, or, and, not_a}
   function automatic logic [5:0] golden_out(input logic a, input logic b);
      return {~(a | b), ~(a & b), a ^ b, a | b, a & b, ~a};
   endfunction

endpackage

// File: rtl/gate_golden.sv
// Combinational expected-value generator for the gate bank under test.
module gate_golden
   import gate_chk_pkg::*;
(
   input  logic       a,
   input  logic       b,
   output logic [5:0] expected
);

   assign expected = golden_out(a, b);

endmodule

// File: rtl/gate_stim_check.sv
// Sweeps {t_a,t_b} through 00..11, waits SETTLE cycles per vector and
// compares the gate bank outputs against the golden values.
//
// state       | meaning
// IDLE        | waiting for start, outputs cleared
// DRIVE       | first cycle of a vector window
// SETTLE_WAIT | settle cycles; compare on terminal count
// DONE        | sweep finished, results held until next start
module gate_stim_check
   import gate_chk_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       t_a,
   output logic       t_b,
   input  logic [5:0] gate_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_mask
);

   localparam logic [2:0] SETTLE_CNT = 3'(SETTLE);

   state_t     state, state_nxt;
   logic [1:0] vec, vec_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic [2:0] err_nxt;
   logic [3:0] mask_nxt;
   logic [5:0] golden;
   logic       compare;
   logic       mismatch;

   gate_golden u_golden (
      .a        (vec[1]),
      .b        (vec[0]),
      .expected (golden)
   );

   assign mismatch = (gate_out != golden);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         vec       <= 2'd0;
         cnt       <= 3'd0;
         err_count <= 3'd0;
         fail_mask <= 4'd0;
      end else begin
         state     <= state_nxt;
         vec       <= vec_nxt;
         cnt       <= cnt_nxt;
         err_count <= err_nxt;
         fail_mask <= mask_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      vec_nxt   = vec;
      cnt_nxt   = cnt;
      err_nxt   = err_count;
      mask_nxt  = fail_mask;
      compare   = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = DRIVE;
               vec_nxt   = 2'd0;
               cnt_nxt   = 3'd0;
               err_nxt   = 3'd0;
               mask_nxt  = 4'd0;
            end
         end
         DRIVE: begin
            if (SETTLE == 0) begin
               compare = 1'b1;
            end else begin
               cnt_nxt   = SETTLE_CNT;
               state_nxt = SETTLE_WAIT;
            end
         end
         SETTLE_WAIT: begin
            if (cnt <= 3'd1) compare = 1'b1;
            else             cnt_nxt = cnt - 3'd1;
         end
         default: state_nxt = IDLE;
      endcase

      // compare edge also loads the next vector
      if (compare) begin
         cnt_nxt = 3'd0;
         if (mismatch) begin
            if (err_count < 3'(NUM_VEC)) err_nxt = err_count + 3'd1;
            mask_nxt[vec] = 1'b1;
         end
         if (vec == 2'(NUM_VEC - 1)) begin
            state_nxt = DONE;
            vec_nxt   = 2'd0;
         end else begin
            state_nxt = DRIVE;
            vec_nxt   = vec + 2'd1;
         end
      end
   end

   assign t_a  = vec[1];
   assign t_b  = vec[0];
   assign busy = (state == DRIVE) || (state == SETTLE_WAIT);
   assign done = (state == DONE);
   assign pass = done && (err_count == 3'd0);

endmodule

// File: tb/tb_gate_stim_check.sv
// Directed bench: table of faulted gate banks plus restart, reset and SETTLE=0 cases.
module tb_gate_stim_check;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       t_a, t_b, busy, done, pass;
   logic [2:0] err_count;
   logic [3:0] fail_mask;
   logic [5:0] gate_out;
   logic       t_a0, t_b0, busy0, done0, pass0;
   logic [2:0] err_count0;
   logic [3:0] fail_mask0;
   logic [5:0] gate_out0;
   int         fault = 0;
   int         n_pass = 0;
   int         n_total = 0;

   always #5 clk = ~clk;

   gate_stim_check #(.SETTLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .t_a(t_a), .t_b(t_b),
      .gate_out(gate_out), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_mask(fail_mask)
   );

   gate_stim_check #(.SETTLE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .t_a(t_a0), .t_b(t_b0),
      .gate_out(gate_out0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err_count0), .fail_mask(fail_mask0)
   );

   // gate bank model with one selectable fault
   always_comb begin
      gate_out = {~(t_a | t_b), ~(t_a & t_b), t_a ^ t_b, t_a | t_b, t_a & t_b, ~t_a};
      case (fault)
         1: gate_out[1] = 1'b0;
         2: gate_out[3] = ~gate_out[3];
         3: gate_out[0] = 1'b1;
         4: gate_out[5] = 1'b0;
         5: gate_out[2] = 1'b1;
         6: gate_out[4] = 1'b0;
         default: ;
      endcase
   end

   assign gate_out0 = {~(t_a0 | t_b0), ~(t_a0 & t_b0), t_a0 ^ t_b0, t_a0 | t_b0, t_a0 & t_b0, ~t_a0};

   typedef struct {
      int         fault;
      logic       exp_pass;
      logic [2:0] exp_err;
      logic [3:0] exp_mask;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else            n_pass++;
   endtask

   // lat: negedges after the start edge until done; snap = {done,err,mask} right after start
   task automatic sweep(input int repulse, output int lat, output int lat0,
                        output bit seq_ok, output logic [7:0] snap);
      lat = -1;
      lat0 = -1;
      seq_ok = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      snap = {done, err_count, fail_mask};
      for (int i = 0; i < 20 && lat < 0; i++) begin
         if (i > 0) @(negedge clk);
         start = (i == repulse);
         if (done0 && lat0 < 0) lat0 = i;
         if (done) lat = i;
         else begin
            if ({t_a, t_b} != 2'(i / 2)) seq_ok = 1'b0;
            if (pass || !busy) seq_ok = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      int         lat, lat0;
      bit         seq_ok;
      logic [7:0] snap;

      tbl[0] = '{0, 1'b1, 3'd0, 4'b0000};
      tbl[1] = '{1, 1'b0, 3'd1, 4'b1000};
      tbl[2] = '{2, 1'b0, 3'd4, 4'b1111};
      tbl[3] = '{3, 1'b0, 3'd2, 4'b1100};
      tbl[4] = '{4, 1'b0, 3'd1, 4'b0001};
      tbl[5] = '{5, 1'b0, 3'd1, 4'b0001};
      tbl[6] = '{6, 1'b0, 3'd3, 4'b0111};

      repeat (3) @(negedge clk);
      chk("reset_outputs", int'({t_a, t_b, busy, done, pass, err_count, fail_mask}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_after_release", int'({busy, done, pass}), 0);

      for (int k = 0; k < 7; k++) begin
         fault = tbl[k].fault;
         sweep(-1, lat, lat0, seq_ok, snap);
         chk($sformatf("latency_f%0d", k), lat, 8);
         chk($sformatf("sequence_f%0d", k), int'(seq_ok), 1);
         chk($sformatf("pass_f%0d", k), int'(pass), int'(tbl[k].exp_pass));
         chk($sformatf("err_count_f%0d", k), int'(err_count), int'(tbl[k].exp_err));
         chk($sformatf("fail_mask_f%0d", k), int'(fail_mask), int'(tbl[k].exp_mask));
      end

      // start re-pulsed mid-sweep is ignored
      fault = 2;
      sweep(3, lat, lat0, seq_ok, snap);
      chk("repulse_latency", lat, 8);
      chk("repulse_sequence", int'(seq_ok), 1);
      chk("repulse_err", int'(err_count), 4);
      chk("repulse_mask", int'(fail_mask), 15);

      // restart from DONE clears results; SETTLE=0 instance runs alongside
      fault = 0;
      sweep(-1, lat, lat0, seq_ok, snap);
      chk("restart_cleared", int'(snap), 0);
      chk("restart_latency", lat, 8);
      chk("restart_pass", int'(pass), 1);
      chk("settle0_latency", lat0, 4);
      chk("settle0_pass", int'(pass0), 1);
      chk("settle0_err", int'(err_count0), 0);

      // reset at cycle 5 of a faulted sweep
      fault = 2;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_reset_err", int'(err_count), 2);
      rst_n = 1'b0;
      #1;
      chk("reset_mid_outputs", int'({t_a, t_b, busy, done, pass, err_count, fail_mask}), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_done_after_abort", int'({busy, done}), 0);
      fault = 0;
      sweep(-1, lat, lat0, seq_ok, snap);
      chk("post_reset_latency", lat, 8);
      chk("post_reset_sequence", int'(seq_ok), 1);
      chk("post_reset_pass", int'(pass), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
